// File: rtl/arc4_pkg.sv
// arc4_pkg: types and constants shared by the ARC4 pipeline stages.
//   prga_state_t  - PRGA FSM state encoding
//   ARC4_ASCII_LO / ARC4_ASCII_HI - printable range for the plaintext check
//   ARC4_S_SIZE   - number of entries in the S permutation memory
package arc4_pkg;

  localparam int         ARC4_S_SIZE   = 256;
  localparam logic [7:0] ARC4_ASCII_LO = 8'h20;
  localparam logic [7:0] ARC4_ASCII_HI = 8'h7E;

  typedef enum logic [3:0] {
    IDLE, LEN_A, LEN_W, LEN_R,
    STEP, SI_W, SI_R, SJ_W, SJ_R,
    WR_I, PAD_A, PAD_W, PAD_R
  } prga_state_t;

  function automatic logic is_ascii(input logic [7:0] b);
    return (b >= ARC4_ASCII_LO) && (b <= ARC4_ASCII_HI);
  endfunction

endpackage

// File: rtl/arc4_prga_if.sv
// arc4_prga_if: start handshake plus the S, ciphertext and plaintext memory
// buses of the PRGA stage.
//   master - the PRGA side (drives addresses, write data, rdy)
//   slave  - the memory/controller side
// Optional: ARC4_PRGA_VALID_EN adds the valid signal.
interface arc4_prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;
`ifdef ARC4_PRGA_VALID_EN
  logic       valid;
`endif

  modport master (
`ifdef ARC4_PRGA_VALID_EN
    output valid,
`endif
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
`ifdef ARC4_PRGA_VALID_EN
    input  valid,
`endif
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_prga.sv
// arc4_prga: ARC4 keystream generation and decryption.
// Reads n = ct[0], then for k = 1..n advances i/j, swaps S[i]/S[j] and writes
// pt[k] = ct[k] ^ S[S[i]+S[j]]. pt[0] receives n. Owns the S port while busy.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - arc4_prga_if.master: en/rdy handshake, S read/write port,
//                ct read port, pt write port (all outputs registered)
// Optional: ARC4_PRGA_VALID_EN adds bus.valid; a plaintext byte outside
// 0x20..0x7E clears valid and ends the run after that byte is written.
module arc4_prga
  import arc4_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  arc4_prga_if.master bus
);

  localparam int K_W = $clog2(ARC4_S_SIZE) + 1;

  prga_state_t    state;
  logic [7:0]     n, i, j, si, sj, c;
  logic [K_W-1:0] k;
  logic           done;

  // k is one bit wider than n so that n = 255 terminates at k = 256.
`ifdef ARC4_PRGA_VALID_EN
  assign done = (k > {1'b0, n}) || !bus.valid;
`else
  assign done = (k > {1'b0, n});
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.rdy       <= 1'b1;
      bus.s_addr    <= '0;
      bus.s_wrdata  <= '0;
      bus.s_wren    <= 1'b0;
      bus.ct_addr   <= '0;
      bus.pt_addr   <= '0;
      bus.pt_wrdata <= '0;
      bus.pt_wren   <= 1'b0;
`ifdef ARC4_PRGA_VALID_EN
      bus.valid     <= 1'b0;
`endif
      n  <= '0;
      i  <= '0;
      j  <= '0;
      k  <= '0;
      si <= '0;
      sj <= '0;
      c  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.en) begin
          bus.rdy <= 1'b0;
`ifdef ARC4_PRGA_VALID_EN
          bus.valid <= 1'b1;
`endif
          state <= LEN_A;
        end
        LEN_A: begin
          bus.ct_addr <= '0;
          state       <= LEN_W;
        end
        LEN_W: state <= LEN_R;
        LEN_R: begin
          n             <= bus.ct_rddata;
          bus.pt_addr   <= '0;
          bus.pt_wrdata <= bus.ct_rddata;
          bus.pt_wren   <= 1'b1;
          i     <= '0;
          j     <= '0;
          k     <= K_W'(1);
          state <= STEP;
        end
        STEP: begin
          bus.pt_wren <= 1'b0;
          if (done) begin
            bus.rdy <= 1'b1;
            state   <= IDLE;
          end else begin
            i           <= i + 8'd1;
            bus.s_addr  <= i + 8'd1;
            bus.ct_addr <= k[7:0];
            state       <= SI_W;
          end
        end
        SI_W: state <= SI_R;
        SI_R: begin
          si         <= bus.s_rddata;
          c          <= bus.ct_rddata;
          j          <= j + bus.s_rddata;
          bus.s_addr <= j + bus.s_rddata;
          state      <= SJ_W;
        end
        SJ_W: state <= SJ_R;
        // Swap: S[j] <= si, then S[i] <= sj. When i == j both writes carry si
        // (sj was read from the same entry), so the entry is unchanged.
        SJ_R: begin
          sj           <= bus.s_rddata;
          bus.s_addr   <= j;
          bus.s_wrdata <= si;
          bus.s_wren   <= 1'b1;
          state        <= WR_I;
        end
        WR_I: begin
          bus.s_addr   <= i;
          bus.s_wrdata <= sj;
          state        <= PAD_A;
        end
        PAD_A: begin
          bus.s_wren <= 1'b0;
          bus.s_addr <= si + sj;
          state      <= PAD_W;
        end
        PAD_W: state <= PAD_R;
        PAD_R: begin
          bus.pt_addr   <= k[7:0];
          bus.pt_wrdata <= bus.s_rddata ^ c;
          bus.pt_wren   <= 1'b1;
`ifdef ARC4_PRGA_VALID_EN
          if (!is_ascii(bus.s_rddata ^ c)) bus.valid <= 1'b0;
`endif
          k     <= k + K_W'(1);
          state <= STEP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_prga.sv
// tb_arc4_prga: directed bench for arc4_prga with behavioural synchronous
// memories for S, ct and pt, and a software ARC4 model for the long run.
module tb_arc4_prga;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arc4_prga_if bus();
  arc4_prga dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] s_mem  [ARC4_S_SIZE];
  logic [7:0] ct_mem [ARC4_S_SIZE];
  logic [7:0] pt_mem [ARC4_S_SIZE];

  logic       ld_en = 1'b0;
  logic [1:0] ld_sel = 2'd0;
  logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
  logic       mon_clr = 1'b1;
  logic       s_wren_q = 1'b0;
  int         s_wr_cyc = 0, s_wr_runs = 0, pt_wr_cnt = 0;

  int errors = 0, checks = 0;

  // Memories: read data registered from the previous cycle's address.
  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
    if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    s_wren_q <= bus.s_wren;
    if (mon_clr) begin
      s_wr_cyc  <= 0;
      s_wr_runs <= 0;
      pt_wr_cnt <= 0;
    end else begin
      if (bus.s_wren) s_wr_cyc <= s_wr_cyc + 1;
      if (bus.s_wren && !s_wren_q) s_wr_runs <= s_wr_runs + 1;
      if (bus.pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
    end
    if (ld_en) begin
      case (ld_sel)
        2'd0:    s_mem[ld_addr]  <= ld_data;
        2'd1:    ct_mem[ld_addr] <= ld_data;
        default: pt_mem[ld_addr] <= ld_data;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] sel, input int a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = a[7:0]; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_identity();
    for (int x = 0; x < ARC4_S_SIZE; x++) load(2'd0, x, x[7:0]);
  endtask

  task automatic clear_pt();
    for (int x = 0; x < ARC4_S_SIZE; x++) load(2'd2, x, 8'hEE);
  endtask

  task automatic clr_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(posedge clk); #1; mon_clr = 1'b0;
  endtask

  task automatic setup_case1();
    load_identity();
    clear_pt();
    load(2'd1, 0, 8'd2);
    load(2'd1, 1, 8'h41);
    load(2'd1, 2, 8'h41);
    clr_mon();
  endtask

  // Accept on edge 0, then count edges until rdy is seen high.
  // pulse_at: raise en for one cycle after that edge (0 = none).
  // rst_at: reset applies on that edge and the run stops there (0 = none).
  task automatic run(input int pulse_at, input int rst_at, output int cyc);
    int guard;
    guard = 0;
    cyc = 0;
    while (!bus.rdy && guard < 100) begin @(posedge clk); #1; guard++; end
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1; bus.en = 1'b0;
    chk("rdy_low_after_accept", {31'd0, bus.rdy}, 32'd0);
    while (cyc < 3000) begin
      if (rst_at != 0 && cyc == rst_at - 1) rst_n = 1'b0;
      @(posedge clk); #1; cyc++;
      bus.en = 1'b0;
      if (cyc == pulse_at) bus.en = 1'b1;
      if (rst_at != 0 && cyc == rst_at) break;
      if (bus.rdy) break;
    end
  endtask

  task automatic check_case1(input string tag, input int cyc);
    int bad;
    bad = 0;
    chk({tag, "_pt0"}, pt_mem[0], 8'd2);
    chk({tag, "_pt1"}, pt_mem[1], 8'h43);
    chk({tag, "_pt2"}, pt_mem[2], 8'h44);
    chk({tag, "_pt3_untouched"}, pt_mem[3], 8'hEE);
    chk({tag, "_s2"}, s_mem[2], 8'd3);
    chk({tag, "_s3"}, s_mem[3], 8'd2);
    for (int x = 0; x < ARC4_S_SIZE; x++)
      if (x != 2 && x != 3 && s_mem[x] !== x[7:0]) bad++;
    chk({tag, "_s_other_bad"}, bad, 0);
    chk({tag, "_cycles"}, cyc, 22);
    chk({tag, "_s_wren_cycles"}, s_wr_cyc, 4);
    chk({tag, "_s_wren_runs"}, s_wr_runs, 2);
    chk({tag, "_pt_writes"}, pt_wr_cnt, 3);
`ifdef ARC4_PRGA_VALID_EN
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
`endif
  endtask

  logic [7:0] sr [ARC4_S_SIZE];
  logic [7:0] ctv [ARC4_S_SIZE];
  logic [7:0] ptv [ARC4_S_SIZE];

  initial begin
    int cyc, snap_s, snap_pt, r;
    logic [7:0] mi, mj, t, ks, p;

    rst_n = 1'b0;
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, bus.rdy}, 32'd1);
    chk("rst_s_wren", {31'd0, bus.s_wren}, 32'd0);
    chk("rst_pt_wren", {31'd0, bus.pt_wren}, 32'd0);
    chk("rst_s_addr", bus.s_addr, 8'd0);
    chk("rst_ct_addr", bus.ct_addr, 8'd0);
    chk("rst_pt_addr", bus.pt_addr, 8'd0);
    chk("rst_s_wrdata", bus.s_wrdata, 8'd0);
    chk("rst_pt_wrdata", bus.pt_wrdata, 8'd0);
`ifdef ARC4_PRGA_VALID_EN
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
`endif
    rst_n = 1'b1;

    // Case 1: identity S, two 'A' bytes.
    setup_case1();
    run(0, 0, cyc);
    check_case1("c1", cyc);

    // Case 2: empty message.
    load_identity();
    clear_pt();
    load(2'd1, 0, 8'd0);
    clr_mon();
    run(0, 0, cyc);
    chk("c2_pt0", pt_mem[0], 8'd0);
    chk("c2_pt1_untouched", pt_mem[1], 8'hEE);
    chk("c2_s_wren_cycles", s_wr_cyc, 0);
    chk("c2_cycles", cyc, 4);

`ifdef ARC4_PRGA_VALID_EN
    // Case 3: first plaintext byte 0x02 is non-printable, run stops after it.
    load_identity();
    clear_pt();
    load(2'd1, 0, 8'd2);
    load(2'd1, 1, 8'h00);
    load(2'd1, 2, 8'h41);
    clr_mon();
    run(0, 0, cyc);
    chk("c3_pt0", pt_mem[0], 8'd2);
    chk("c3_pt1", pt_mem[1], 8'h02);
    chk("c3_pt2_untouched", pt_mem[2], 8'hEE);
    chk("c3_valid", {31'd0, bus.valid}, 32'd0);
    chk("c3_cycles", cyc, 13);
`endif

    // Case 4: random permutation, n = 255. Plaintext is chosen printable so
    // the run also completes when the validity check is built in.
    for (int x = 0; x < ARC4_S_SIZE; x++) sr[x] = x[7:0];
    for (int x = ARC4_S_SIZE - 1; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = sr[x]; sr[x] = sr[r]; sr[r] = t;
    end
    for (int x = 0; x < ARC4_S_SIZE; x++) load(2'd0, x, sr[x]);
    mi = 8'd0; mj = 8'd0;
    for (int kk = 1; kk <= 255; kk++) begin
      mi = mi + 8'd1;
      mj = mj + sr[mi];
      t = sr[mi]; sr[mi] = sr[mj]; sr[mj] = t;
      t = sr[mi] + sr[mj];
      ks = sr[t];
      p = 8'($urandom_range(126, 32));
      ptv[kk] = p;
      ctv[kk] = p ^ ks;
    end
    clear_pt();
    load(2'd1, 0, 8'd255);
    for (int kk = 1; kk <= 255; kk++) load(2'd1, kk, ctv[kk]);
    clr_mon();
    run(0, 0, cyc);
    chk("c4_cycles", cyc, 2299);
    chk("c4_pt0", pt_mem[0], 8'd255);
    for (int kk = 1; kk <= 255; kk++) chk($sformatf("c4_pt%0d", kk), pt_mem[kk], ptv[kk]);
    for (int x = 0; x < ARC4_S_SIZE; x++) chk($sformatf("c4_s%0d", x), s_mem[x], sr[x]);
    chk("c4_s_wren_runs", s_wr_runs, 255);
`ifdef ARC4_PRGA_VALID_EN
    chk("c4_valid", {31'd0, bus.valid}, 32'd1);
`endif

    // Case 5: en pulsed mid-run is ignored.
    setup_case1();
    run(7, 0, cyc);
    check_case1("c5", cyc);

    // Case 6: reset at cycle 10, then a clean rerun.
    setup_case1();
    run(0, 10, cyc);
    chk("c6_rst_cycle", cyc, 10);
    chk("c6_rdy", {31'd0, bus.rdy}, 32'd1);
    chk("c6_s_wren", {31'd0, bus.s_wren}, 32'd0);
    chk("c6_pt_wren", {31'd0, bus.pt_wren}, 32'd0);
    chk("c6_s_addr", bus.s_addr, 8'd0);
    rst_n = 1'b1;
    snap_s = s_wr_cyc;
    snap_pt = pt_wr_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("c6_no_s_writes", s_wr_cyc, snap_s);
    chk("c6_no_pt_writes", pt_wr_cnt, snap_pt);
    setup_case1();
    run(0, 0, cyc);
    check_case1("c6", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
